conv_row_sequencer: RTL
=======================

# conv_row_sequencer

Controller for one convolution layer pass. It steps the receptive-field selector through every output row and both column halves of the image, and pulses the convolution-unit array through clear/compute. For each result it presents one half-row write to the downstream feature-map buffer with a valid/ready handshake. It sits between the layer top (start/done) and the selector → conv-unit datapath.

## Interface
Parameters:
- D, 1, input depth (used only for the CONV_LAT default)
- H, 32, image height
- W, 32, image width
- F, 5, filter size
- CONV_LAT, F*F*D, cycles the conv units need with conv_en high to produce a result

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high; forces IDLE
- start  input  1  begin a layer pass; sampled only in IDLE
- rowNumber  output  6  output-row index driven to the selector; range 0..H-F
- column  output  6  half select driven to the selector; 0 = first (W-F+1)/2 columns, 1 = second half
- conv_clear  output  1  one-cycle pulse; clears the conv-unit accumulators
- conv_en  output  1  conv units compute while high
- out_valid  output  1  conv results valid for the current (rowNumber, column)
- out_ready  input  1  downstream accepts; a transfer occurs when out_valid && out_ready
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when the last half-row has been transferred

## Operation
- State machine has five states: IDLE, SETUP, COMPUTE, WRITE, DONE.
- IDLE:
  - rowNumber=0, column=0.
  - start=1 → SETUP.
- SETUP:
  - Lasts 1 cycle. The selector output settles and conv_clear=1.
  - Next state is COMPUTE. The cycle counter loads 0.
- COMPUTE:
  - conv_en=1. The counter increments each cycle.
  - When counter==CONV_LAT-1 → WRITE. The state lasts exactly CONV_LAT cycles.
- WRITE:
  - out_valid=1. rowNumber and column are held stable.
  - Stays in WRITE until out_ready=1.
  - On transfer:
    - column==0 → column=1, then SETUP.
    - column==1 and rowNumber<H-F → rowNumber+1, column=0, then SETUP.
    - column==1 and rowNumber==H-F → DONE.
- DONE:
  - done=1 for 1 cycle, then IDLE.
  - rowNumber and column return to 0 on entry to IDLE.
- start is ignored outside IDLE. start held high in IDLE after DONE begins a new pass.
- Total half-row passes: 2*(H-F+1), which is 56 at the defaults.
- Counter width is $clog2(CONV_LAT)+1. CONV_LAT ≥ 1 is required. rowNumber never exceeds H-F and never wraps.

## Timing
- All outputs are registered or decoded from registered state. There are no combinational paths from inputs to outputs.
- Reset values: rowNumber=0, column=0, conv_clear=0, conv_en=0, out_valid=0, busy=0, done=0, state=IDLE.
- Reset mid-operation takes effect immediately (asynchronous):
  - All outputs return to their reset values.
  - No partial write completes.
  - The pass is abandoned. A fresh start is required.
- Timing from start sampled at edge 0 (out_ready tied high):
  - Each pass is CONV_LAT+2 cycles.
  - Pass p's SETUP is the cycle after edge p*(CONV_LAT+2).
  - done is high in the cycle after edge 2*(H-F+1)*(CONV_LAT+2): 1512 at the defaults.
- Back-pressure:
  - Each cycle out_ready=0 in WRITE extends the pass by one cycle.
  - conv_en stays 0 during the stall.
  - rowNumber and column do not change until the transfer edge.
- conv_en and out_valid are never high in the same cycle. conv_clear is never high with either of them.
- Transfer on the final half-row and done: done rises the cycle after the transfer edge. busy falls together with done's fall.

## Test plan
- Reset/idle:
  - Stimulus: assert reset, release, hold start=0 for 10 cycles.
  - Required: all outputs 0, busy=0, no conv_clear.
- Full pass, no stall:
  - Stimulus: CONV_LAT=3, out_ready=1, start pulse.
  - Required: 56 transfers in order (0,0),(0,1),(1,0)…(27,1); done exactly 280 cycles after the start edge; each conv_en run exactly 3 cycles preceded by one conv_clear.
- Back-pressure:
  - Stimulus: out_ready=0 for 4 cycles on transfer (5,1).
  - Required: out_valid held with rowNumber=5, column=1 stable; done delayed by exactly 4 cycles versus the previous test.
- Reset mid-operation:
  - Stimulus: assert reset during COMPUTE of (10,0).
  - Required: outputs return to reset values immediately; no further out_valid; a later start restarts at (0,0).
- Start ignored while busy:
  - Stimulus: pulse start repeatedly during a pass.
  - Required: sequence and done timing identical to the full-pass test; a single done.
- Default parameters:
  - Stimulus: CONV_LAT=25 with random out_ready (50%).
  - Required: transfer count 56; last transfer (27,1); done follows it by 1 cycle; conv_en high for 25 cycles per pass.

Source files
------------

// File: rtl/conv_row_sequencer.sv
// conv_row_sequencer: steps the selector over every output row / column half and sequences clear, compute and write-out.
module conv_row_sequencer #(
    parameter int D        = 1,
    parameter int H        = 32,
    parameter int W        = 32,
    parameter int F        = 5,
    parameter int CONV_LAT = F * F * D
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [5:0] rowNumber,
    output logic [5:0] column,
    output logic       conv_clear,
    output logic       conv_en,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done
);
    localparam int CW = $clog2(CONV_LAT) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(CONV_LAT - 1);
    localparam logic [5:0] LAST_ROW = 6'(H - F);

    if (CONV_LAT < 1 || F > H || F > W || H - F > 63) begin : g_bad_params
        $error("conv_row_sequencer: unsupported parameter combination");
    end

    typedef enum logic [2:0] {IDLE, SETUP, COMPUTE, WRITE, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0]    row_q, row_d;
    logic          col_q, col_d;

    // state, latency counter and selector position registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            row_q   <= '0;
            col_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    // next state: the selector position only advances on a completed transfer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        col_d   = col_q;
        case (state_q)
            IDLE: begin
                row_d = '0;
                col_d = 1'b0;
                if (start) state_d = SETUP;
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = COMPUTE;
            end
            COMPUTE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) state_d = WRITE;
            end
            WRITE: begin
                if (out_ready) begin
                    if (!col_q) begin
                        col_d   = 1'b1;
                        state_d = SETUP;
                    end else if (row_q != LAST_ROW) begin
                        row_d   = row_q + 6'd1;
                        col_d   = 1'b0;
                        state_d = SETUP;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                row_d   = '0;
                col_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rowNumber  = row_q;
    assign column     = {5'd0, col_q};
    assign conv_clear = (state_q == SETUP);
    assign conv_en    = (state_q == COMPUTE);
    assign out_valid  = (state_q == WRITE);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
endmodule
